// File: rtl/light_package.sv
// Shared light/phase types for the intersection controllers.
//   colors      : per-light colour, RED encodes as zero so an all-zero bus is all red.
//   tlc_phase_t : phase of the shared green/yellow/all-red sequencer.
//   tlc_max     : maximum of two values, usable in constant expressions.
//   tlc_ctr_w   : width needed to hold the largest of four cycle counts.
package light_package;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } tlc_phase_t;

  function automatic int unsigned tlc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The +1 keeps $clog2 from returning zero when every count is 1.
  function automatic int unsigned tlc_ctr_w(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    return $clog2(tlc_max(tlc_max(a, b), tlc_max(c, d)) + 1);
  endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin pick over N_DIR request lines.
//   req_i         : request per channel, bit i is channel i.
//   last_i        : channel granted most recently; searched last.
//   grant_valid_o : at least one request is set.
//   grant_dir_o   : first requesting channel after last_i, wrapping around.
module tlc_rr_arbiter #(
  parameter  int unsigned N_DIR = 3,
  localparam int unsigned DIR_W = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req_i,
  input  logic [DIR_W-1:0] last_i,
  output logic             grant_valid_o,
  output logic [DIR_W-1:0] grant_dir_o
);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_dir_o   = last_i;
    // Walk from the farthest offset to the nearest so the nearest requester wins.
    for (int off = int'(N_DIR); off >= 1; off--) begin
      int idx;
      idx = (int'(last_i) + off) % int'(N_DIR);
      if (req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_dir_o   = DIR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-direction traffic light controller with one shared green/yellow/all-red sequencer,
// round-robin direction selection and a level-sensitive emergency preempt.
//   clk           : clock.
//   reset         : synchronous, active-high reset.
//   sensor_i      : traffic present per direction.
//   preempt_req_i : emergency preempt request.
//   preempt_dir_i : direction to serve while preempting; out-of-range values are ignored.
//   lights_o      : colour per direction (light_package::colors encoding).
//   active_dir_o  : direction owning the current or most recent green.
//   phase_o       : current sequencer phase.
module traffic_light_controller_n
  import light_package::*;
#(
  parameter  int unsigned N_DIR      = 3,
  parameter  int unsigned IDLE_TO    = 5,
  parameter  int unsigned MAX_GREEN  = 10,
  parameter  int unsigned YELLOW_CYC = 2,
  parameter  int unsigned ALLRED_CYC = 1,
  localparam int unsigned DIR_W      = $clog2(N_DIR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIR-1:0]      sensor_i,
  input  logic                  preempt_req_i,
  input  logic [DIR_W-1:0]      preempt_dir_i,
  output logic [N_DIR-1:0][1:0] lights_o,
  output logic [DIR_W-1:0]      active_dir_o,
  output tlc_phase_t            phase_o
);

  localparam int unsigned CTR_W = tlc_ctr_w(IDLE_TO, MAX_GREEN, YELLOW_CYC, ALLRED_CYC);
  localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
  localparam logic [CTR_W-1:0] IDLE_LAST   = CTR_W'(IDLE_TO - 1);
  localparam logic [CTR_W-1:0] MAX_LAST    = CTR_W'(MAX_GREEN - 1);
  localparam logic [CTR_W-1:0] YELLOW_LAST = CTR_W'(YELLOW_CYC - 1);
  localparam logic [CTR_W-1:0] ALLRED_LAST = CTR_W'(ALLRED_CYC - 1);

  tlc_phase_t             phase_q, phase_d;
  logic [DIR_W-1:0]       active_dir_q, active_dir_d;
  logic [CTR_W-1:0]       idle_ctr_q, idle_ctr_d;
  logic [CTR_W-1:0]       max_ctr_q, max_ctr_d;
  logic [CTR_W-1:0]       phase_ctr_q, phase_ctr_d;
  // Set once the all-red minimum has elapsed; reset sets it so the first edge can grant.
  logic                   allred_met_q, allred_met_d;
  logic [N_DIR-1:0][1:0]  lights_q, lights_d;

  logic                   pre_valid;
  logic                   own_req;
  logic                   other_req;
  logic                   rr_valid;
  logic [DIR_W-1:0]       rr_dir;
  logic                   allred_ok;

  tlc_rr_arbiter #(
    .N_DIR(N_DIR)
  ) u_rr_arbiter (
    .req_i        (sensor_i),
    .last_i       (active_dir_q),
    .grant_valid_o(rr_valid),
    .grant_dir_o  (rr_dir)
  );

  always_comb begin
    pre_valid = preempt_req_i && (32'(preempt_dir_i) < N_DIR);
    own_req   = 1'b0;
    other_req = 1'b0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      if (DIR_W'(i) == active_dir_q) begin
        own_req = own_req | sensor_i[i];
      end else begin
        other_req = other_req | sensor_i[i];
      end
    end
    allred_ok = allred_met_q || (phase_ctr_q == ALLRED_LAST);
  end

  always_comb begin
    phase_d      = phase_q;
    active_dir_d = active_dir_q;
    idle_ctr_d   = idle_ctr_q;
    max_ctr_d    = max_ctr_q;
    phase_ctr_d  = phase_ctr_q;
    allred_met_d = allred_met_q;

    unique case (phase_q)
      PH_GREEN: begin
        if (pre_valid && (preempt_dir_i != active_dir_q)) begin
          phase_d     = PH_YELLOW;
          idle_ctr_d  = '0;
          max_ctr_d   = '0;
          phase_ctr_d = '0;
        end else if (pre_valid) begin
          // Preempt already owns the green: hold it with the timers parked.
          idle_ctr_d = '0;
          max_ctr_d  = '0;
        end else if ((idle_ctr_q == IDLE_LAST) || (max_ctr_q == MAX_LAST)) begin
          phase_d     = PH_YELLOW;
          idle_ctr_d  = '0;
          max_ctr_d   = '0;
          phase_ctr_d = '0;
        end else begin
          // Both timers latch on once started, even if the triggering condition clears.
          if (!own_req || (idle_ctr_q != '0)) begin
            idle_ctr_d = idle_ctr_q + CTR_ONE;
          end
          if ((own_req && other_req) || (max_ctr_q != '0)) begin
            max_ctr_d = max_ctr_q + CTR_ONE;
          end
        end
      end

      PH_YELLOW: begin
        if (phase_ctr_q == YELLOW_LAST) begin
          phase_d      = PH_ALLRED;
          phase_ctr_d  = '0;
          allred_met_d = 1'b0;
        end else begin
          phase_ctr_d = phase_ctr_q + CTR_ONE;
        end
      end

      PH_ALLRED: begin
        if (!allred_ok) begin
          phase_ctr_d = phase_ctr_q + CTR_ONE;
        end else begin
          allred_met_d = 1'b1;
          if (pre_valid || rr_valid) begin
            phase_d      = PH_GREEN;
            active_dir_d = pre_valid ? preempt_dir_i : rr_dir;
            phase_ctr_d  = '0;
            idle_ctr_d   = '0;
            max_ctr_d    = '0;
          end
        end
      end

      default: begin
        phase_d      = PH_ALLRED;
        phase_ctr_d  = '0;
        allred_met_d = 1'b1;
      end
    endcase
  end

  // Lights are decoded from the next state so they register alongside the phase.
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      if (DIR_W'(i) == active_dir_d) begin
        if (phase_d == PH_GREEN) begin
          lights_d[i] = GREEN;
        end else if (phase_d == PH_YELLOW) begin
          lights_d[i] = YELLOW;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_ALLRED;
      active_dir_q <= DIR_W'(N_DIR - 1);
      idle_ctr_q   <= '0;
      max_ctr_q    <= '0;
      phase_ctr_q  <= '0;
      allred_met_q <= 1'b1;
      lights_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      active_dir_q <= active_dir_d;
      idle_ctr_q   <= idle_ctr_d;
      max_ctr_q    <= max_ctr_d;
      phase_ctr_q  <= phase_ctr_d;
      allred_met_q <= allred_met_d;
      lights_q     <= lights_d;
    end
  end

  assign lights_o     = lights_q;
  assign active_dir_o = active_dir_q;
  assign phase_o      = phase_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
module tb_traffic_light_controller_n;
  import light_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (3 directions). Instance B: 4 directions, 3-cycle yellow, 2-cycle all-red.
  logic            rst_a, rst_b;
  logic [2:0]      sens_a;
  logic [3:0]      sens_b;
  logic            pre_req_a, pre_req_b;
  logic [1:0]      pre_dir_a, pre_dir_b;
  logic [2:0][1:0] lights_a;
  logic [3:0][1:0] lights_b;
  logic [1:0]      dir_a, dir_b;
  tlc_phase_t      ph_a, ph_b;

  traffic_light_controller_n u_dut_a (
    .clk          (clk),
    .reset        (rst_a),
    .sensor_i     (sens_a),
    .preempt_req_i(pre_req_a),
    .preempt_dir_i(pre_dir_a),
    .lights_o     (lights_a),
    .active_dir_o (dir_a),
    .phase_o      (ph_a)
  );

  traffic_light_controller_n #(
    .N_DIR     (4),
    .YELLOW_CYC(3),
    .ALLRED_CYC(2)
  ) u_dut_b (
    .clk          (clk),
    .reset        (rst_b),
    .sensor_i     (sens_b),
    .preempt_req_i(pre_req_b),
    .preempt_dir_i(pre_dir_b),
    .lights_o     (lights_b),
    .active_dir_o (dir_b),
    .phase_o      (ph_b)
  );

  typedef struct {
    bit         on_b;
    tlc_phase_t ph;
    logic [1:0] dir;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_lights(input int n, input tlc_phase_t ph,
                                            input logic [1:0] dir);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (i == int'(dir) && ph == PH_GREEN) v[2*i +: 2] = GREEN;
      else if (i == int'(dir) && ph == PH_YELLOW) v[2*i +: 2] = YELLOW;
    end
    return v;
  endfunction

  // Drive one row for n cycles, queueing the state expected after each edge.
  task automatic step(input bit b, input logic [3:0] s, input logic pr, input logic [1:0] pd,
                      input logic rst, input tlc_phase_t ph, input logic [1:0] dir, input int n,
                      input string tag);
    for (int k = 0; k < n; k++) begin
      if (!b) begin
        sens_a = s[2:0]; pre_req_a = pr; pre_dir_a = pd; rst_a = rst;
      end else begin
        sens_b = s; pre_req_b = pr; pre_dir_b = pd; rst_b = rst;
      end
      q.push_back('{b, ph, dir, tag});
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expectation per cycle, and checks the single-non-red rule on both DUTs.
  always @(negedge clk) begin
    int nr_a, nr_b;
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (!e.on_b) begin
        chk({e.tag, " phase"}, int'(ph_a), int'(e.ph));
        chk({e.tag, " dir"}, int'(dir_a), int'(e.dir));
        chk({e.tag, " lights"}, int'(8'(lights_a)), int'(exp_lights(3, e.ph, e.dir)));
      end else begin
        chk({e.tag, " phase"}, int'(ph_b), int'(e.ph));
        chk({e.tag, " dir"}, int'(dir_b), int'(e.dir));
        chk({e.tag, " lights"}, int'(8'(lights_b)), int'(exp_lights(4, e.ph, e.dir)));
      end
    end
    nr_a = 0;
    nr_b = 0;
    for (int i = 0; i < 3; i++) if (lights_a[i] != 2'b00) nr_a++;
    for (int i = 0; i < 4; i++) if (lights_b[i] != 2'b00) nr_b++;
    chk("a_one_nonred", int'(nr_a > 1), 0);
    chk("b_one_nonred", int'(nr_b > 1), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    sens_a = '0; pre_req_a = 1'b0; pre_dir_a = '0; rst_a = 1'b1;
    sens_b = '0; pre_req_b = 1'b0; pre_dir_b = '0; rst_b = 1'b1;

    // Reset state.
    step(0, 4'b000, 0, 0, 1, PH_ALLRED, 2, 2, "rst");

    // 1: short burst on dir0 -> 5 green, 2 yellow, all-red hold.
    step(0, 4'b001, 0, 0, 0, PH_GREEN,  0, 1, "t1_grant");
    step(0, 4'b000, 0, 0, 0, PH_GREEN,  0, 4, "t1_idle");
    step(0, 4'b000, 0, 0, 0, PH_YELLOW, 0, 2, "t1_yel");
    step(0, 4'b000, 0, 0, 0, PH_ALLRED, 0, 3, "t1_hold");

    // 2: all sensors busy -> 10-cycle greens rotating 0,1,2,0.
    step(0, 4'b001, 0, 0, 0, PH_GREEN,  0, 1, "t2_grant0");
    step(0, 4'b111, 0, 0, 0, PH_GREEN,  0, 9, "t2_max0");
    step(0, 4'b111, 0, 0, 0, PH_YELLOW, 0, 2, "t2_yel0");
    step(0, 4'b111, 0, 0, 0, PH_ALLRED, 0, 1, "t2_ar0");
    step(0, 4'b111, 0, 0, 0, PH_GREEN,  1, 10, "t2_max1");
    step(0, 4'b111, 0, 0, 0, PH_YELLOW, 1, 2, "t2_yel1");
    step(0, 4'b111, 0, 0, 0, PH_ALLRED, 1, 1, "t2_ar1");
    step(0, 4'b111, 0, 0, 0, PH_GREEN,  2, 10, "t2_max2");
    step(0, 4'b111, 0, 0, 0, PH_YELLOW, 2, 2, "t2_yel2");
    step(0, 4'b111, 0, 0, 0, PH_ALLRED, 2, 1, "t2_ar2");
    step(0, 4'b111, 0, 0, 0, PH_GREEN,  0, 1, "t2_wrap0");

    // 3: own traffic drops then returns; idle timer keeps running.
    step(0, 4'b001, 0, 0, 0, PH_GREEN,  0, 2, "t3_busy");
    step(0, 4'b000, 0, 0, 0, PH_GREEN,  0, 2, "t3_drop");
    step(0, 4'b001, 0, 0, 0, PH_GREEN,  0, 2, "t3_back");
    step(0, 4'b001, 0, 0, 0, PH_YELLOW, 0, 2, "t3_yel");
    step(0, 4'b000, 0, 0, 0, PH_ALLRED, 0, 2, "t3_ar");

    // 4: preempt to dir2 during dir1 green.
    step(0, 4'b010, 0, 0, 0, PH_GREEN,  1, 4, "t4_green1");
    step(0, 4'b010, 1, 2, 0, PH_YELLOW, 1, 2, "t4_pre_yel");
    step(0, 4'b010, 1, 2, 0, PH_ALLRED, 1, 1, "t4_pre_ar");
    step(0, 4'b010, 1, 2, 0, PH_GREEN,  2, 5, "t4_pre_hold");
    step(0, 4'b000, 0, 0, 0, PH_GREEN,  2, 4, "t4_release");
    step(0, 4'b000, 0, 0, 0, PH_YELLOW, 2, 2, "t4_yel2");
    step(0, 4'b000, 0, 0, 0, PH_ALLRED, 2, 1, "t4_ar2");
    step(0, 4'b000, 1, 3, 0, PH_ALLRED, 2, 2, "t4_bad_dir");

    // 5: reset in yellow, then immediate grant after reset.
    step(0, 4'b001, 0, 0, 0, PH_GREEN,  0, 1, "t5_grant0");
    step(0, 4'b000, 0, 0, 0, PH_GREEN,  0, 4, "t5_idle");
    step(0, 4'b000, 0, 0, 0, PH_YELLOW, 0, 1, "t5_yel");
    step(0, 4'b000, 0, 0, 1, PH_ALLRED, 2, 1, "t5_rst");
    step(0, 4'b000, 0, 0, 0, PH_ALLRED, 2, 2, "t5_after");
    step(0, 4'b010, 0, 0, 0, PH_GREEN,  1, 1, "t5_grant1");
    step(0, 4'b010, 0, 0, 1, PH_ALLRED, 2, 1, "t5_rst_green");
    step(0, 4'b000, 0, 0, 0, PH_ALLRED, 2, 1, "t5_idle_ar");

    // 6: 4 directions, 3-cycle yellow, 2-cycle all-red.
    step(1, 4'b0000, 0, 0, 1, PH_ALLRED, 3, 2, "t6_rst");
    step(1, 4'b1000, 0, 0, 0, PH_GREEN,  3, 1, "t6_grant3");
    step(1, 4'b0000, 0, 0, 0, PH_GREEN,  3, 4, "t6_idle");
    step(1, 4'b0000, 0, 0, 0, PH_YELLOW, 3, 3, "t6_yel");
    step(1, 4'b1000, 0, 0, 0, PH_ALLRED, 3, 2, "t6_ar");
    step(1, 4'b1000, 0, 0, 0, PH_GREEN,  3, 1, "t6_regrant");
    step(1, 4'b0000, 0, 0, 1, PH_ALLRED, 3, 1, "t6_rst_end");

    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_n.md
Name: traffic_light_controller_n

Overview:
Parametrised N-direction successor to the 3-street, 12-state controller. It has one green/yellow/all-red phase sequencer shared across N_DIR directions and configurable timeouts. It selects the next direction by round-robin over the sensors and adds an emergency preempt. It drives one light per direction from the top-level intersection wrapper, using the shared red/yellow/green type.

Parameters:
N_DIR, 3, number of conflicting directions (2..8).
IDLE_TO, 5, green ends IDLE_TO cycles after own traffic goes away.
MAX_GREEN, 10, green limit in cycles once conflicting traffic is waiting.
YELLOW_CYC, 2, yellow duration in cycles (>=1).
ALLRED_CYC, 1, minimum all-red duration in cycles (>=1).
DIR_W, $clog2(N_DIR), width of a direction index (derived, do not override).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
sensor  in  N_DIR  traffic present per direction; bit i is direction i.
preempt_req  in  1  emergency preempt request, level-sensitive.
preempt_dir  in  DIR_W  direction to serve while preempt_req=1.
lights  out  N_DIR x colors  light per direction.
active_dir  out  DIR_W  direction owning the current or most recent green.
phase  out  tlc_phase_t  current phase: PH_GREEN, PH_YELLOW or PH_ALLRED.

Behaviour:
- Reset:
  - Registered state: phase=PH_ALLRED, active_dir=N_DIR-1, all counters 0.
  - All-red minimum counts as already satisfied, so a grant can occur on the first edge after reset.
  - All lights red.
- Moore outputs:
  - lights[active_dir] is green in PH_GREEN and yellow in PH_YELLOW.
  - Every other light, and every light in PH_ALLRED, is red.
  - At most one light is ever non-red.
- PH_GREEN counters:
  - idle_ctr increments when sensor[active_dir]=0 or idle_ctr!=0. Once started, it keeps counting even if traffic returns.
  - max_ctr increments when (sensor[active_dir]=1 and any other sensor=1) or max_ctr!=0.
  - Exit to PH_YELLOW on the edge where idle_ctr==IDLE_TO-1 or max_ctr==MAX_GREEN-1. Both counters clear on exit.
  - With the defaults: green lasts 5 cycles after own traffic leaves, or 10 cycles from first conflict.
- Preempt during PH_GREEN:
  - preempt_req=1 with preempt_dir!=active_dir: go to PH_YELLOW on the next edge, overriding the counters.
  - preempt_req=1 with preempt_dir==active_dir: hold green and hold both counters at 0.
- PH_YELLOW: lasts exactly YELLOW_CYC cycles (phase_ctr 0..YELLOW_CYC-1), then goes to PH_ALLRED. It is never shortened or extended, preempt included.
- PH_ALLRED:
  - Lasts at least ALLRED_CYC cycles. After the minimum, it grants on the first cycle with a request.
  - If preempt_req=1, grant preempt_dir regardless of sensors.
  - Otherwise grant the first set sensor bit searching active_dir+1, active_dir+2, ... with wrap-around, and active_dir last.
  - With no request, stay in PH_ALLRED with active_dir unchanged; lights stay red.
  - A grant sets active_dir and moves to PH_GREEN on the same edge.
- preempt_dir >= N_DIR is ignored and treated as preempt_req=0.
- Counter width: $clog2(max(IDLE_TO,MAX_GREEN,YELLOW_CYC,ALLRED_CYC)+1). No wrap is reachable.
- Reset mid-operation: on the next edge go to PH_ALLRED with all red, whatever the phase; yellow is not completed.
- Sensors are sampled only at the clock edge; glitches between edges have no effect.

Decomposition:
- light_package (existing) gains:
  - typedef enum tlc_phase_t {PH_GREEN, PH_YELLOW, PH_ALLRED};
  - function clog2-safe max helper.
- colors stays as is, in light_package.
- One sub-module: tlc_rr_arbiter, a combinational round-robin pick.
  - Inputs: req[N_DIR], last[DIR_W].
  - Outputs: grant_valid, grant_dir.
  - Instantiated once and reused by other multi-channel blocks.

Test Plan:
1. Reset, then sensor=3'b001 for 1 cycle then 0 → dir0 green 5 cycles, then 2 yellow, then all-red holds; active_dir=0.
2. Dir0 green with sensor=3'b111 held → dir0 green exactly 10 cycles, 2 yellow, 1 all-red, then dir1 green; next round gives dir2, then dir0.
3. Dir0 green with sensor[0] dropping at cycle 2 and reasserting at cycle 4 → yellow still occurs 5 cycles after the drop, because idle_ctr does not restart.
4. Dir1 green, preempt_req=1 and preempt_dir=2 asserted mid-green → yellow next cycle, 2 yellow, 1 all-red, dir2 green even with sensor[2]=0, held while the preempt is held.
5. Reset asserted during PH_YELLOW → all red on the next cycle, phase=PH_ALLRED, active_dir=N_DIR-1.
6. N_DIR=4, YELLOW_CYC=3, ALLRED_CYC=2, sensor=4'b1000 → dir3 green first, yellow lasts 3 cycles, all-red lasts 2; the bench asserts in every cycle that at most one light is non-red.
